// File: rtl/id_stream_gen_pkg.sv
// Shared definitions for the identifier character-stream generator and the recognizer bench.
package id_stream_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LETTER = 2'd1,
      ST_DIGIT  = 2'd2,
      ST_SEP    = 2'd3
   } gen_state_t;

   localparam logic [7:0] ASCII_LC_A = 8'h61;
   localparam logic [7:0] ASCII_UC_A = 8'h41;
   localparam logic [7:0] ASCII_ZERO = 8'h30;

   localparam int unsigned LETTER_RANGE = 26;
   localparam int unsigned DIGIT_RANGE  = 10;
   localparam int unsigned LETTER_IDX_W = $clog2(LETTER_RANGE);
   localparam int unsigned DIGIT_IDX_W  = $clog2(DIGIT_RANGE);

   // One presented character plus its recognizer expectation.
   typedef struct packed {
      logic [7:0] ch;
      logic       id_expect;
   } char_beat_t;

   function automatic logic [7:0] letter_char(input logic upper,
                                              input logic [LETTER_IDX_W-1:0] idx);
      return (upper ? ASCII_UC_A : ASCII_LC_A) + 8'(idx);
   endfunction

endpackage

// File: rtl/id_stream_gen_mod_counter.sv
// Wrapping modulo-MOD index with load and increment; exposes the next-cycle
// value so the caller can register outputs derived from it without extra lag.
module id_stream_gen_mod_counter #(
   parameter int unsigned MOD = 10,
   parameter int unsigned W   = $clog2(MOD)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   output logic [W-1:0] idx_c
);

   logic [W-1:0] idx_q;
   logic [W-1:0] reduced;
   logic [W-1:0] wrapped;

   // Load values up to 2*MOD-1 are folded back into range.
   always_comb begin
      reduced = (load_val >= W'(MOD)) ? (load_val - W'(MOD)) : load_val;
      wrapped = (idx_q == W'(MOD - 1)) ? '0 : (idx_q + W'(1));
      idx_c   = idx_q;
      if (load)
         idx_c = reduced;
      else if (inc)
         idx_c = wrapped;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         idx_q <= '0;
      else
         idx_q <= idx_c;
   end

endmodule

// File: rtl/id_stream_gen.sv
// Emits tokens of N letters, M digits and one separator, one character per
// valid/ready handshake, flagging digits that follow at least one letter.
module id_stream_gen
   import id_stream_gen_pkg::*;
#(
   parameter int unsigned LEN_W    = 4,
   parameter logic [7:0]  SEP_CHAR = 8'h20,
   parameter bit          UPPER    = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [LEN_W-1:0]        n_letters,
   input  logic [LEN_W-1:0]        n_digits,
   input  logic [LETTER_IDX_W-1:0] base,
   output logic [7:0]              char,
   output logic                    char_valid,
   input  logic                    char_ready,
   output logic                    id_expect,
   output logic                    busy,
   output logic                    done
);

   gen_state_t             state_q, state_n;
   logic [LEN_W-1:0]       nl_q, nl_n;
   logic [LEN_W-1:0]       nd_q, nd_n;
   logic [LEN_W-1:0]       kcnt_q, kcnt_n;
   logic [LEN_W-1:0]       jcnt_q, jcnt_n;
   logic                   l_load, l_inc;
   logic                   d_load, d_inc;
   logic                   done_n;
   logic                   xfer;
   logic [LETTER_IDX_W-1:0] l_idx_c;
   logic [DIGIT_IDX_W-1:0]  d_idx_c;
   char_beat_t             beat_n;

   assign xfer = char_valid & char_ready;

   id_stream_gen_mod_counter #(
      .MOD (LETTER_RANGE),
      .W   (LETTER_IDX_W)
   ) u_letter_idx (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (l_load),
      .load_val (base),
      .inc      (l_inc),
      .idx_c    (l_idx_c)
   );

   id_stream_gen_mod_counter #(
      .MOD (DIGIT_RANGE),
      .W   (DIGIT_IDX_W)
   ) u_digit_idx (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (d_load),
      .load_val ('0),
      .inc      (d_inc),
      .idx_c    (d_idx_c)
   );

   // State and counters describe the character that will be presented next cycle.
   always_comb begin
      state_n = state_q;
      nl_n    = nl_q;
      nd_n    = nd_q;
      kcnt_n  = kcnt_q;
      jcnt_n  = jcnt_q;
      l_load  = 1'b0;
      l_inc   = 1'b0;
      d_load  = 1'b0;
      d_inc   = 1'b0;
      done_n  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               nl_n   = n_letters;
               nd_n   = n_digits;
               kcnt_n = '0;
               jcnt_n = '0;
               l_load = 1'b1;
               d_load = 1'b1;
               if (n_letters != '0)
                  state_n = ST_LETTER;
               else if (n_digits != '0)
                  state_n = ST_DIGIT;
               else
                  state_n = ST_SEP;
            end
         end
         ST_LETTER: begin
            if (xfer) begin
               if ((kcnt_q + LEN_W'(1)) == nl_q) begin
                  state_n = (nd_q != '0) ? ST_DIGIT : ST_SEP;
               end else begin
                  kcnt_n = kcnt_q + LEN_W'(1);
                  l_inc  = 1'b1;
               end
            end
         end
         ST_DIGIT: begin
            if (xfer) begin
               if ((jcnt_q + LEN_W'(1)) == nd_q) begin
                  state_n = ST_SEP;
               end else begin
                  jcnt_n = jcnt_q + LEN_W'(1);
                  d_inc  = 1'b1;
               end
            end
         end
         ST_SEP: begin
            if (xfer) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Character mux from next state and next indices; registered below.
   always_comb begin
      beat_n = '0;
      unique case (state_n)
         ST_LETTER: beat_n.ch = letter_char(1'(UPPER), l_idx_c);
         ST_DIGIT: begin
            beat_n.ch        = ASCII_ZERO + 8'(d_idx_c);
            beat_n.id_expect = (nl_n != '0);
         end
         ST_SEP:  beat_n.ch = SEP_CHAR;
         default: beat_n    = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         nl_q       <= '0;
         nd_q       <= '0;
         kcnt_q     <= '0;
         jcnt_q     <= '0;
         char       <= '0;
         char_valid <= 1'b0;
         id_expect  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_n;
         nl_q       <= nl_n;
         nd_q       <= nd_n;
         kcnt_q     <= kcnt_n;
         jcnt_q     <= jcnt_n;
         char       <= beat_n.ch;
         char_valid <= (state_n != ST_IDLE);
         id_expect  <= beat_n.id_expect;
         busy       <= (state_n != ST_IDLE);
         done       <= done_n;
      end
   end

endmodule

// File: tb/tb_id_stream_gen.sv
// Randomized scoreboard bench for id_stream_gen: a token-level model fills the
// expected-character queue, a negedge monitor pops and compares on every transfer.
module tb_id_stream_gen;
   import id_stream_gen_pkg::*;

   localparam int unsigned LEN_W = 4;
   localparam logic [7:0]  SEP   = 8'h20;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] n_letters = '0;
   logic [LEN_W-1:0] n_digits = '0;
   logic [4:0]       base = '0;
   logic [7:0]       char;
   logic             char_valid;
   logic             char_ready = 1'b1;
   logic             id_expect;
   logic             busy;
   logic             done;

   id_stream_gen #(
      .LEN_W    (LEN_W),
      .SEP_CHAR (SEP),
      .UPPER    (1'b0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .n_letters  (n_letters),
      .n_digits   (n_digits),
      .base       (base),
      .char       (char),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .id_expect  (id_expect),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   char_beat_t exp_q[$];
   int         n_pass = 0;
   int         n_chk = 0;
   int         ready_mode = 0;
   int         ph = 0;
   logic       expect_done = 1'b0;
   logic       stall_prev = 1'b0;
   char_beat_t held;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Token as text: letters from base with wrap, digits 0..9 repeating, then separator.
   function automatic void model(input int nl, input int nd, input int b);
      for (int k = 0; k < nl; k++)
         exp_q.push_back('{ch: 8'(32'h61 + ((b % 26) + k) % 26), id_expect: 1'b0});
      for (int j = 0; j < nd; j++)
         exp_q.push_back('{ch: 8'(32'h30 + j % 10), id_expect: (nl > 0)});
      exp_q.push_back('{ch: SEP, id_expect: 1'b0});
   endfunction

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1: begin
            char_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
            ph++;
         end
         2:       char_ready = ($urandom_range(0, 9) < 7);
         default: char_ready = 1'b1;
      endcase
   end

   always @(negedge clk) begin
      char_beat_t e;
      if (!rst_n) begin
         exp_q.delete();
         expect_done = 1'b0;
         stall_prev  = 1'b0;
      end else begin
         chk("done_pulse", 32'(done), 32'(expect_done));
         if (stall_prev) begin
            chk("stall_char", 32'(char), 32'(held.ch));
            chk("stall_valid", 32'(char_valid), 32'd1);
            chk("stall_id_expect", 32'(id_expect), 32'(held.id_expect));
         end
         expect_done = 1'b0;
         if (char_valid && char_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL extra_char: got %0h expected none at %0t", char, $time);
            end else begin
               e = exp_q.pop_front();
               chk("char", 32'(char), 32'(e.ch));
               chk("id_expect", 32'(id_expect), 32'(e.id_expect));
               expect_done = (e.ch == SEP);
            end
         end
         stall_prev = char_valid && !char_ready;
         held       = '{ch: char, id_expect: id_expect};
      end
   end

   task automatic wait_done(input string name);
      int n;
      for (n = 0; n < 600; n++) begin
         @(negedge clk);
         if (done) break;
      end
      if (n == 600) begin
         n_chk++;
         $display("FAIL %s_timeout: got no done expected done within 600 cycles", name);
      end else begin
         chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      end
   endtask

   task automatic send_token(input int nl, input int nd, input int b, input bit poke);
      int n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      n_letters = LEN_W'(nl);
      n_digits  = LEN_W'(nd);
      base      = 5'(b);
      start     = 1'b1;
      model(nl, nd, b);
      @(posedge clk);
      #1 start = 1'b0;
      if (poke) begin
         @(negedge clk);
         if (busy) begin
            n_letters = LEN_W'(nl ^ 5);
            n_digits  = LEN_W'(nd + 3);
            base      = 5'(b + 7);
            start     = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
         end
      end
      wait_done("token");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         start = ~start;
         #1;
         chk("rst_valid", 32'(char_valid), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_char", 32'(char), 32'd0);
      end
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      send_token(2, 3, 0, 1'b0);
      send_token(3, 12, 24, 1'b0);

      ready_mode = 1;
      ph = 0;
      send_token(1, 1, 0, 1'b0);
      send_token(4, 6, 9, 1'b0);
      ready_mode = 0;

      send_token(0, 0, 5, 1'b0);
      send_token(0, 2, 0, 1'b0);
      send_token(3, 3, 2, 1'b1);
      send_token(2, 1, 30, 1'b0);

      // Start in the done cycle: exactly one idle cycle before the next first char.
      send_token(1, 0, 3, 1'b0);
      chk("b2b_busy", 32'(busy), 32'd0);
      chk("b2b_idle_valid", 32'(char_valid), 32'd0);
      n_letters = '0;
      n_digits  = LEN_W'(1);
      base      = '0;
      start     = 1'b1;
      model(0, 1, 0);
      @(posedge clk);
      #1 start = 1'b0;
      chk("b2b_first_valid", 32'(char_valid), 32'd1);
      wait_done("b2b");

      ready_mode = 2;
      repeat (25)
         send_token(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0));
      ready_mode = 0;

      // Reset while digits are being emitted.
      @(negedge clk);
      n_letters = LEN_W'(2);
      n_digits  = LEN_W'(5);
      base      = '0;
      start     = 1'b1;
      model(2, 5, 0);
      @(posedge clk);
      #1 start = 1'b0;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (id_expect) break;
      end
      chk("reached_digit", 32'(id_expect), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(char_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_id_expect", 32'(id_expect), 32'd0);
      chk("midrst_char", 32'(char), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      send_token(1, 1, 0, 1'b0);

      repeat (3) @(negedge clk);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
